writeback_unit: RTL and testbench

- Write-side companion to the 31x64 RV64I register file.
- Collects results from two producers, arbitrates between them and drives the register file write port: the single-cycle ALU path, and the long-latency load path with valid/ready handshake, buffered in a small FIFO.
- Extracts and sign/zero-extends load data.
- Keeps a pending-write scoreboard so decode can stall on registers that still have a load in flight.

---
 rtl/writeback_unit.sv | 162 ++++++++++++++++
 tb/tb_writeback_unit.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: arbitrates the single-cycle ALU path and the buffered load
// return path onto the register file write port, extends load data, and
// keeps a pending-load scoreboard for decode.
// Optional: `define WB_STARVE_GUARD_EN to stall the ALU when a buffered load
// has waited STARVE_LIMIT cycles.
module writeback_unit #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [63:0] alu_data_i,
  input  logic        mem_valid_i,
  output logic        mem_ready_o,
  input  logic [4:0]  mem_rd_i,
  input  logic [63:0] mem_data_i,
  input  logic [2:0]  mem_funct3_i,
  input  logic [2:0]  mem_addr_lo_i,
  output logic [4:0]  rd_idx_o,
  output logic [63:0] wr_data_o,
  output logic        wr_en_o,
  input  logic [4:0]  rs1_idx_i,
  input  logic [4:0]  rs2_idx_i,
  output logic        rs1_busy_ao,
  output logic        rs2_busy_ao,
  output logic        alu_stall_o
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [2:0]  lo;
    logic [63:0] data;
  } ld_ent_t;

  ld_ent_t        fifo_q [FIFO_DEPTH];
  logic [PW-1:0]  wptr_q, rptr_q;
  logic [PW:0]    cnt_q;
  logic [31:0]    sb_q, sb_d;
  logic           stall_q;
  ld_ent_t        head;
  logic           full, empty, push, pop, alu_win;
  logic [63:0]    ld_ext;
  logic [63:0]    sh_b, sh_h, sh_w;

  assign full        = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty       = (cnt_q == '0);
  assign mem_ready_o = !full;
  assign push        = mem_valid_i && !full;
  assign head        = fifo_q[rptr_q];
  // An rd==0 ALU result is dropped, which lets a buffered load use the slot.
  assign alu_win     = !stall_q && alu_valid_i && (alu_rd_i != 5'd0);
  assign pop         = !alu_win && !empty;
  assign alu_stall_o = stall_q;

  // Load buffer payload; pointers alone define validity so no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wptr_q] <= '{rd: mem_rd_i, funct3: mem_funct3_i,
                                  lo: mem_addr_lo_i, data: mem_data_i};
  end

  // Load buffer pointers and occupancy; pointers wrap as FIFO_DEPTH is 2^n.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Lane select by byte offset, then sign/zero extension by funct3.
  always_comb begin
    sh_b   = head.data >> {head.lo, 3'b000};
    sh_h   = head.data >> {head.lo[2:1], 4'b0000};
    sh_w   = head.data >> {head.lo[2], 5'b00000};
    ld_ext = head.data;
    case (head.funct3)
      3'b000:  ld_ext = {{56{sh_b[7]}},  sh_b[7:0]};
      3'b001:  ld_ext = {{48{sh_h[15]}}, sh_h[15:0]};
      3'b010:  ld_ext = {{32{sh_w[31]}}, sh_w[31:0]};
      3'b100:  ld_ext = {56'd0, sh_b[7:0]};
      3'b101:  ld_ext = {48'd0, sh_h[15:0]};
      3'b110:  ld_ext = {32'd0, sh_w[31:0]};
      default: ld_ext = head.data;
    endcase
  end

  // Registered write port: winner of cycle N is presented in cycle N+1.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_en_o   <= 1'b0;
      rd_idx_o  <= 5'd0;
      wr_data_o <= 64'd0;
    end else if (alu_win) begin
      wr_en_o   <= 1'b1;
      rd_idx_o  <= alu_rd_i;
      wr_data_o <= alu_data_i;
    end else if (pop) begin
      wr_en_o   <= (head.rd != 5'd0);
      rd_idx_o  <= head.rd;
      wr_data_o <= ld_ext;
    end else begin
      wr_en_o   <= 1'b0;
    end
  end

  // Scoreboard next state: pop clears, issue sets and wins on a collision.
  always_comb begin
    sb_d = sb_q;
    if (pop) sb_d[head.rd] = 1'b0;
    if (issue_valid_i) sb_d[issue_rd_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sb_q <= '0;
    else         sb_q <= sb_d;
  end

  assign rs1_busy_ao = sb_q[rs1_idx_i];
  assign rs2_busy_ao = sb_q[rs2_idx_i];

`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q;

  // Count cycles the head load waits; stall the ALU on the edge the count
  // reaches the limit and release it on the edge that pops the head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      if (pop)
        starve_q <= '0;
      else if (!empty && (int'(starve_q) < STARVE_LIMIT))
        starve_q <= starve_q + 1'b1;
      if (stall_q)
        stall_q <= !pop;
      else if (!empty && !pop && (int'(starve_q) + 1 >= STARVE_LIMIT))
        stall_q <= 1'b1;
    end
  end
`else
  assign stall_q = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [63:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_rd;
  logic [63:0] mem_data;
  logic [2:0]  mem_f3;
  logic [2:0]  mem_lo;
  logic [4:0]  rd_idx;
  logic [63:0] wr_data;
  logic        wr_en;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy, alu_stall;

  int checks = 0;
  int failures = 0;

  writeback_unit #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd),
    .alu_valid_i(alu_valid), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .mem_valid_i(mem_valid), .mem_ready_o(mem_ready), .mem_rd_i(mem_rd),
    .mem_data_i(mem_data), .mem_funct3_i(mem_f3), .mem_addr_lo_i(mem_lo),
    .rd_idx_o(rd_idx), .wr_data_o(wr_data), .wr_en_o(wr_en),
    .rs1_idx_i(rs1), .rs2_idx_i(rs2),
    .rs1_busy_ao(rs1_busy), .rs2_busy_ao(rs2_busy), .alu_stall_o(alu_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_valid = 0; issue_rd = 0; alu_valid = 0; alu_rd = 0;
    alu_data = 0; mem_valid = 0; mem_rd = 0; mem_data = 0; mem_f3 = 0;
    mem_lo = 0; rs1 = 5'd1; rs2 = 5'd2;
    tick(); tick();
    checks++;
    if ({wr_en, rd_idx, wr_data, alu_stall} !== 71'd0) begin
      failures++; $display("FAIL reset_outputs got en=%b rd=%0d data=%h stall=%b want 0",
                           wr_en, rd_idx, wr_data, alu_stall);
    end
    checks++;
    if (mem_ready !== 1'b1 || rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      failures++; $display("FAIL reset_ready_busy got ready=%b b1=%b b2=%b want 1 0 0",
                           mem_ready, rs1_busy, rs2_busy);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    alu_valid = 1; alu_rd = 5'd5; alu_data = 64'h1234;
    tick();
    alu_valid = 0;
    checks++;
    if (wr_en !== 1'b1 || rd_idx !== 5'd5 || wr_data !== 64'h1234) begin
      failures++; $display("FAIL alu_write got en=%b rd=%0d data=%h want 1 5 1234",
                           wr_en, rd_idx, wr_data);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin
      failures++; $display("FAIL alu_one_cycle got en=%b want 0", wr_en);
    end
  endtask

  task automatic load_vec(input logic [2:0] f3, input logic [2:0] lo,
                          input logic [63:0] d, input logic [63:0] exp, input string nm);
    mem_valid = 1; mem_rd = 5'd7; mem_f3 = f3; mem_lo = lo; mem_data = d;
    tick();
    mem_valid = 0;
    tick();
    checks++;
    if (wr_en !== 1'b1 || rd_idx !== 5'd7 || wr_data !== exp) begin
      failures++; $display("FAIL load_%s got en=%b rd=%0d data=%h want 1 7 %h",
                           nm, wr_en, rd_idx, wr_data, exp);
    end
  endtask

  task automatic test_load_ext();
    load_vec(3'b000, 3'd3, 64'h00000000_80000000, 64'hFFFFFFFF_FFFFFF80, "lb");
    load_vec(3'b100, 3'd3, 64'h00000000_80000000, 64'h00000000_00000080, "lbu");
    load_vec(3'b110, 3'd4, 64'hDEADBEEF_00000000, 64'h00000000_DEADBEEF, "lwu");
    load_vec(3'b001, 3'd2, 64'h00000000_80010000, 64'hFFFFFFFF_FFFF8001, "lh");
    load_vec(3'b101, 3'd6, 64'hBEEF0000_00000000, 64'h00000000_0000BEEF, "lhu");
    load_vec(3'b010, 3'd5, 64'h80000000_00000000, 64'hFFFFFFFF_80000000, "lw_misal");
    load_vec(3'b011, 3'd1, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF, "ld");
    load_vec(3'b111, 3'd0, 64'hFEDCBA98_76543210, 64'hFEDCBA98_76543210, "f3_111");
  endtask

  task automatic test_scoreboard();
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0; rs1 = 5'd9; #1;
    checks++;
    if (rs1_busy !== 1'b1) begin
      failures++; $display("FAIL sb_set got busy=%b want 1", rs1_busy);
    end
    mem_valid = 1; mem_rd = 5'd9; mem_f3 = 3'b011; mem_lo = 0; mem_data = 64'h99;
    tick();
    mem_valid = 0;
    checks++;
    if (rs1_busy !== 1'b1) begin
      failures++; $display("FAIL sb_buffered got busy=%b want 1", rs1_busy);
    end
    tick();
    checks++;
    if (wr_en !== 1'b1 || rd_idx !== 5'd9 || rs1_busy !== 1'b0) begin
      failures++; $display("FAIL sb_clear got en=%b rd=%0d busy=%b want 1 9 0",
                           wr_en, rd_idx, rs1_busy);
    end
    issue_valid = 1; issue_rd = 5'd9;
    tick();
    issue_valid = 0;
    mem_valid = 1;
    tick();
    mem_valid = 0; issue_valid = 1;
    tick();
    issue_valid = 0;
    checks++;
    if (wr_en !== 1'b1 || rd_idx !== 5'd9 || rs1_busy !== 1'b1) begin
      failures++; $display("FAIL sb_set_wins got en=%b rd=%0d busy=%b want 1 9 1",
                           wr_en, rd_idx, rs1_busy);
    end
    mem_valid = 1;
    tick();
    mem_valid = 0;
    tick();
    checks++;
    if (rs1_busy !== 1'b0) begin
      failures++; $display("FAIL sb_cleanup got busy=%b want 0", rs1_busy);
    end
  endtask

  task automatic test_full_starve();
    int first_stall = -1;
    int ld10_cyc = -1;
    logic stall_after;
    alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h33;
    mem_valid = 1; mem_rd = 5'd10; mem_f3 = 3'b011; mem_lo = 0; mem_data = 64'h10;
    tick();
    mem_rd = 5'd11; mem_data = 64'h11;
    tick();
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++; $display("FAIL full_ready got %b want 0", mem_ready);
    end
`ifndef WB_STARVE_GUARD_EN
    // Offered while full: must not be accepted.
    mem_rd = 5'd12; mem_data = 64'h12;
    for (int j = 0; j < 6; j++) begin
      tick();
      checks++;
      if (wr_en !== 1'b1 || rd_idx !== 5'd3 || mem_ready !== 1'b0 || alu_stall !== 1'b0) begin
        failures++; $display("FAIL alu_priority cyc=%0d got en=%b rd=%0d ready=%b stall=%b want 1 3 0 0",
                             j, wr_en, rd_idx, mem_ready, alu_stall);
      end
    end
    mem_valid = 0; alu_valid = 0;
    tick();
    checks++;
    if (wr_en !== 1'b1 || rd_idx !== 5'd10 || wr_data !== 64'h10) begin
      failures++; $display("FAIL drain_first got en=%b rd=%0d data=%h want 1 10 10",
                           wr_en, rd_idx, wr_data);
    end
    tick();
    checks++;
    if (wr_en !== 1'b1 || rd_idx !== 5'd11 || wr_data !== 64'h11) begin
      failures++; $display("FAIL drain_second got en=%b rd=%0d data=%h want 1 11 11",
                           wr_en, rd_idx, wr_data);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0 || mem_ready !== 1'b1) begin
      failures++; $display("FAIL no_push_when_full got en=%b ready=%b want 0 1", wr_en, mem_ready);
    end
`else
    mem_valid = 0;
    stall_after = 1'b1;
    for (int j = 3; j <= 12; j++) begin
      tick();
      if (alu_stall && first_stall < 0) first_stall = j;
      if (wr_en && rd_idx == 5'd10 && ld10_cyc < 0) ld10_cyc = j;
      if (j == 6) stall_after = alu_stall;
    end
    checks++;
    if (first_stall != 5) begin
      failures++; $display("FAIL starve_stall_cycle got %0d want 5", first_stall);
    end
    checks++;
    if (ld10_cyc != 6) begin
      failures++; $display("FAIL starve_load_write got %0d want 6", ld10_cyc);
    end
    checks++;
    if (stall_after !== 1'b0) begin
      failures++; $display("FAIL starve_stall_clear got %b want 0", stall_after);
    end
    alu_valid = 0;
    tick(); tick();
    checks++;
    if (wr_en !== 1'b0 || mem_ready !== 1'b1) begin
      failures++; $display("FAIL starve_drained got en=%b ready=%b want 0 1", wr_en, mem_ready);
    end
`endif
  endtask

  task automatic test_rd0();
    issue_valid = 1; issue_rd = 5'd0;
    tick();
    issue_valid = 0; rs1 = 5'd0; rs2 = 5'd0; #1;
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      failures++; $display("FAIL rd0_busy got %b %b want 0 0", rs1_busy, rs2_busy);
    end
    alu_valid = 1; alu_rd = 5'd20; alu_data = 64'h20;
    mem_valid = 1; mem_rd = 5'd0; mem_f3 = 3'b011; mem_lo = 0; mem_data = 64'hAA;
    tick();
    tick();
    mem_valid = 0; alu_rd = 5'd0;
    checks++;
    if (mem_ready !== 1'b0) begin
      failures++; $display("FAIL rd0_fill got ready=%b want 0", mem_ready);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0 || mem_ready !== 1'b1) begin
      failures++; $display("FAIL rd0_pop1 got en=%b ready=%b want 0 1", wr_en, mem_ready);
    end
    tick();
    checks++;
    if (wr_en !== 1'b0) begin
      failures++; $display("FAIL rd0_pop2 got en=%b want 0", wr_en);
    end
    alu_valid = 0;
    tick();
    checks++;
    if (wr_en !== 1'b0 || rs1_busy !== 1'b0) begin
      failures++; $display("FAIL rd0_idle got en=%b busy=%b want 0 0", wr_en, rs1_busy);
    end
  endtask

  task automatic test_reset_mid();
    alu_valid = 1; alu_rd = 5'd3; alu_data = 64'h55;
    for (int r = 1; r <= 3; r++) begin
      issue_valid = 1; issue_rd = 5'(r);
      tick();
    end
    issue_valid = 0;
    mem_valid = 1; mem_rd = 5'd1; mem_f3 = 3'b011; mem_lo = 0; mem_data = 64'h1;
    tick();
    mem_rd = 5'd2;
    tick();
    mem_valid = 0; rs1 = 5'd1; rs2 = 5'd3; #1;
    checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1 || mem_ready !== 1'b0 || wr_en !== 1'b1) begin
      failures++; $display("FAIL pre_reset got b1=%b b2=%b ready=%b en=%b want 1 1 0 1",
                           rs1_busy, rs2_busy, mem_ready, wr_en);
    end
    rst_n = 1'b0; #1;
    checks++;
    if (wr_en !== 1'b0 || rd_idx !== 5'd0 || wr_data !== 64'd0 || mem_ready !== 1'b1) begin
      failures++; $display("FAIL mid_reset_out got en=%b rd=%0d data=%h ready=%b want 0 0 0 1",
                           wr_en, rd_idx, wr_data, mem_ready);
    end
    checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_busy got %b %b want 0 0", rs1_busy, rs2_busy);
    end
    alu_valid = 0;
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (wr_en !== 1'b0 || mem_ready !== 1'b1) begin
      failures++; $display("FAIL post_reset_drain got en=%b ready=%b want 0 1", wr_en, mem_ready);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_ext();
    test_scoreboard();
    test_full_starve();
    test_rd0();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
